// File: rtl/pipe_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_pkg
// Shared definitions for the 5-stage pipeline hazard controller:
//   - hz_state_t      : controller FSM encoding (RUN / EX_BUSY / MEM_WAIT)
//   - FWD_*           : EX operand forwarding mux select codes
//   - FLUSH_*         : bit positions inside flush_mask
//   - flush_bits()    : flush mask for a given branch-resolve stage
// -----------------------------------------------------------------------------
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EX_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam int FLUSH_IF_ID  = 0;
    localparam int FLUSH_ID_EX  = 1;
    localparam int FLUSH_EX_MEM = 2;

    // A branch resolved in stage N has N younger instructions behind it,
    // living in the N pipeline registers closest to fetch.
    function automatic logic [2:0] flush_bits(input int br_stage);
        logic [2:0] m;
        m = '0;
        if (br_stage > FLUSH_IF_ID)  m[FLUSH_IF_ID]  = 1'b1;
        if (br_stage > FLUSH_ID_EX)  m[FLUSH_ID_EX]  = 1'b1;
        if (br_stage > FLUSH_EX_MEM) m[FLUSH_EX_MEM] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// -----------------------------------------------------------------------------
// hazard_src_match
// Single-source register dependency comparator. A producer matches a source
// when it is valid, writes the register file, targets a non-zero register
// and that register equals the source. r0 never matches.
// Ports:
//   i_valid      producer stage holds a valid instruction
//   i_reg_write  producer writes the register file
//   i_dst        producer destination register
//   i_src        consumer source register
//   o_match      dependency present
// -----------------------------------------------------------------------------
module hazard_src_match
    import pipe_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_valid,
    input  logic                  i_reg_write,
    input  logic [REG_ADDR_W-1:0] i_dst,
    input  logic [REG_ADDR_W-1:0] i_src,
    output logic                  o_match
);

    assign o_match = i_valid & i_reg_write & (i_dst != '0) & (i_dst == i_src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard, forwarding and stall/flush controller for the 5-stage pipeline.
// Drives pipeline-register enables, bubble/flush controls and EX forwarding.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_*                           ID-stage instruction sources
//   ex_* / mem_* / wb_*            producer stage controls and destinations
//   ex_mc_start / ex_mc_done       multi-cycle EX op entry pulse / completion
//   mem_busy                       data memory wait state
//   redirect                       taken branch/jump resolved in BR_STAGE
//   pc_we .. mem_wb_we             pipeline register write enables
//   *_bubble                       load a bubble into that register
//   flush_mask                     bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM
//   fwd_sel                        per source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   id_bypass                      ID read takes the WB write value
//   mc_timeout_err                 sticky multi-cycle timeout
//   state                          FSM state (0 RUN, 1 EX_BUSY, 2 MEM_WAIT)
//
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating performance
// counters cyc_cnt, retire_cnt, lu_stall_cnt, mc_stall_cnt, mem_stall_cnt,
// flush_cnt as output ports.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int BR_STAGE   = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          ex_valid,
    input  logic                          ex_reg_write,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_dst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
    input  logic                          ex_mc_start,
    input  logic                          ex_mc_done,
    input  logic                          mem_valid,
    input  logic                          mem_reg_write,
    input  logic [REG_ADDR_W-1:0]         mem_dst,
    input  logic                          mem_busy,
    input  logic                          wb_valid,
    input  logic                          wb_reg_write,
    input  logic [REG_ADDR_W-1:0]         wb_dst,
    input  logic                          redirect,
    output logic                          pc_we,
    output logic                          if_id_we,
    output logic                          id_ex_we,
    output logic                          ex_mem_we,
    output logic                          mem_wb_we,
    output logic                          id_ex_bubble,
    output logic                          ex_mem_bubble,
    output logic                          mem_wb_bubble,
    output logic [2:0]                    flush_mask,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic [NUM_SRC-1:0]            id_bypass,
    output logic                          mc_timeout_err,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [CNT_W-1:0]              cyc_cnt,
    output logic [CNT_W-1:0]              retire_cnt,
    output logic [CNT_W-1:0]              lu_stall_cnt,
    output logic [CNT_W-1:0]              mc_stall_cnt,
    output logic [CNT_W-1:0]              mem_stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt,
`endif
    output logic [1:0]                    state
);

    localparam int         TO_W       = $clog2(MC_TIMEOUT + 1);
    localparam logic [2:0] FLUSH_MASK = flush_bits(BR_STAGE);

    if (BR_STAGE < 1 || BR_STAGE > 3 || MC_TIMEOUT < 1 || CNT_W < 1 || NUM_SRC < 1) begin : g_param_err
        $error("pipe_hazard_ctrl: parameter out of range");
    end

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic             r_mc_pending;
    logic             r_mc_err;
    logic [TO_W-1:0]  r_mc_cnt;

    logic [NUM_SRC-1:0] w_exmem_hit;
    logic [NUM_SRC-1:0] w_memwb_hit;
    logic [NUM_SRC-1:0] w_wb_id_hit;
    logic [NUM_SRC-1:0] w_lu_hit;

    // ---------------------------------------------------------------- matches
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_exmem (
            .i_valid(mem_valid), .i_reg_write(mem_reg_write), .i_dst(mem_dst),
            .i_src(ex_src[g*REG_ADDR_W +: REG_ADDR_W]), .o_match(w_exmem_hit[g]));
        hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_memwb (
            .i_valid(wb_valid), .i_reg_write(wb_reg_write), .i_dst(wb_dst),
            .i_src(ex_src[g*REG_ADDR_W +: REG_ADDR_W]), .o_match(w_memwb_hit[g]));
        hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_wb_id (
            .i_valid(wb_valid), .i_reg_write(wb_reg_write), .i_dst(wb_dst),
            .i_src(id_src[g*REG_ADDR_W +: REG_ADDR_W]), .o_match(w_wb_id_hit[g]));
        hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
            .i_valid(ex_valid), .i_reg_write(ex_reg_write), .i_dst(ex_dst),
            .i_src(id_src[g*REG_ADDR_W +: REG_ADDR_W]), .o_match(w_lu_hit[g]));

        // The younger producer (EX/MEM) holds the newest value, so it wins.
        assign fwd_sel[2*g +: 2] = w_exmem_hit[g] ? FWD_EXMEM :
                                   w_memwb_hit[g] ? FWD_MEMWB : FWD_REGFILE;
        assign id_bypass[g]      = id_valid & id_src_used[g] & w_wb_id_hit[g];
    end

    logic w_load_use;
    assign w_load_use = id_valid & ex_mem_read & |(w_lu_hit & id_src_used);

    // A multi-cycle op that has not completed is still occupying EX. This also
    // covers the MEM_WAIT cycle where mem_busy drops with the op still pending,
    // so younger instructions stay held until ex_mc_done.
    logic w_mc_live;
    logic w_mc_stall;
    logic w_timeout;
    assign w_mc_live  = ~ex_mc_done & (ex_mc_start | r_mc_pending);
    assign w_mc_stall = w_mc_live | ((r_state == ST_EX_BUSY) & ~ex_mc_done);
    assign w_timeout  = (r_state == ST_EX_BUSY) & ~ex_mc_done &
                        (r_mc_cnt == TO_W'(MC_TIMEOUT - 1));

    // Which priority level is in control this cycle.
    logic w_act_redirect;
    logic w_act_mc;
    logic w_act_lu;
    assign w_act_redirect = ~mem_busy & redirect;
    assign w_act_mc       = ~mem_busy & ~redirect & w_mc_stall;
    assign w_act_lu       = ~mem_busy & ~redirect & ~w_mc_stall & w_load_use;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_mc_pending <= 1'b0;
            r_mc_cnt     <= '0;
            r_mc_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (ex_mc_done || w_timeout) r_mc_pending <= 1'b0;
            else if (ex_mc_start)        r_mc_pending <= 1'b1;
            // Held at zero outside EX_BUSY, so every entry starts from zero.
            if (r_state != ST_EX_BUSY) r_mc_cnt <= '0;
            else                       r_mc_cnt <= r_mc_cnt + TO_W'(1);
            if (w_timeout) r_mc_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (mem_busy)                        w_state_nxt = ST_MEM_WAIT;
                else if (ex_mc_start && !ex_mc_done) w_state_nxt = ST_EX_BUSY;
            end
            ST_EX_BUSY: begin
                if (mem_busy)                     w_state_nxt = ST_MEM_WAIT;
                else if (ex_mc_done || w_timeout) w_state_nxt = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) w_state_nxt = w_mc_live ? ST_EX_BUSY : ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------- controls
    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        ex_mem_we     = 1'b1;
        mem_wb_we     = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        flush_mask    = '0;
        if (mem_busy) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_we     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (w_act_redirect) begin
            flush_mask = FLUSH_MASK;
        end else if (w_act_mc) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (w_act_lu) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign mc_timeout_err = r_mc_err;
    assign state          = r_state;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt, r_retire_cnt, r_lu_cnt, r_mc_stall_cnt, r_mem_cnt, r_flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt      <= '0;
            r_retire_cnt   <= '0;
            r_lu_cnt       <= '0;
            r_mc_stall_cnt <= '0;
            r_mem_cnt      <= '0;
            r_flush_cnt    <= '0;
        end else begin
            r_cyc_cnt      <= sat_inc(r_cyc_cnt, 1'b1);
            r_retire_cnt   <= sat_inc(r_retire_cnt, wb_valid);
            r_lu_cnt       <= sat_inc(r_lu_cnt, w_act_lu);
            r_mc_stall_cnt <= sat_inc(r_mc_stall_cnt, w_act_mc);
            r_mem_cnt      <= sat_inc(r_mem_cnt, mem_busy);
            r_flush_cnt    <= sat_inc(r_flush_cnt, w_act_redirect);
        end
    end

    assign cyc_cnt       = r_cyc_cnt;
    assign retire_cnt    = r_retire_cnt;
    assign lu_stall_cnt  = r_lu_cnt;
    assign mc_stall_cnt  = r_mc_stall_cnt;
    assign mem_stall_cnt = r_mem_cnt;
    assign flush_cnt     = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (BR_STAGE=2, MC_TIMEOUT=8).
// The driver applies one cycle of inputs and pushes the expected output word;
// the monitor pops it on the falling edge and compares field by field.
// Expected word: {state[1:0], err, we[4:0] (pc,if_id,id_ex,ex_mem,mem_wb),
//                 bubble[2:0] (id_ex,ex_mem,mem_wb), flush[2:0], fwd[3:0], byp[1:0]}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int RW = 5;
    localparam int NS = 2;
    localparam int BR = 2;
    localparam int TO = 8;
    localparam int CW = 32;
    localparam int EW = 20;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_EXB = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;

    localparam logic [4:0] WE_ALL  = 5'b11111;
    localparam logic [4:0] WE_LU   = 5'b00111;
    localparam logic [4:0] WE_MC   = 5'b00011;
    localparam logic [4:0] WE_NONE = 5'b00000;

    localparam logic [2:0] B_NONE  = 3'b000;
    localparam logic [2:0] B_IDEX  = 3'b100;
    localparam logic [2:0] B_EXMEM = 3'b010;
    localparam logic [2:0] B_MEMWB = 3'b001;

    localparam logic [2:0] FL_NONE = 3'b000;
    localparam logic [2:0] FL_BR   = 3'b011;

    // ------------------------------------------------------- clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           id_valid;
    logic [NS*RW-1:0] id_src;
    logic [NS-1:0]  id_src_used;
    logic           ex_valid, ex_reg_write, ex_mem_read;
    logic [RW-1:0]  ex_dst;
    logic [NS*RW-1:0] ex_src;
    logic           ex_mc_start, ex_mc_done;
    logic           mem_valid, mem_reg_write;
    logic [RW-1:0]  mem_dst;
    logic           mem_busy;
    logic           wb_valid, wb_reg_write;
    logic [RW-1:0]  wb_dst;
    logic           redirect;
    logic           pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic           id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
    logic [2:0]     flush_mask;
    logic [2*NS-1:0] fwd_sel;
    logic [NS-1:0]  id_bypass;
    logic           mc_timeout_err;
    logic [1:0]     state;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CW-1:0]  cyc_cnt, retire_cnt, lu_stall_cnt, mc_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_ADDR_W(RW), .NUM_SRC(NS), .BR_STAGE(BR), .MC_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dst(ex_dst), .ex_src(ex_src), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
        .mem_busy(mem_busy),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
        .redirect(redirect),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_bubble(mem_wb_bubble),
        .flush_mask(flush_mask), .fwd_sel(fwd_sel), .id_bypass(id_bypass),
        .mc_timeout_err(mc_timeout_err),
`ifdef PIPE_HAZARD_PERF_EN
        .cyc_cnt(cyc_cnt), .retire_cnt(retire_cnt), .lu_stall_cnt(lu_stall_cnt),
        .mc_stall_cnt(mc_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state(state)
    );

    // ------------------------------------------------------------ scoreboard
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    string         cur_tag  = "none";
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_got;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [1:0] st, input logic er, input logic [4:0] we,
                                         input logic [2:0] bub, input logic [2:0] fl,
                                         input logic [3:0] fwd, input logic [1:0] byp);
        return {st, er, we, bub, fl, fwd, byp};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {state, mc_timeout_err, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                       id_ex_bubble, ex_mem_bubble, mem_wb_bubble, flush_mask, fwd_sel, id_bypass};
            check({cur_tag, ".state"},  32'(mon_got[19:18]), 32'(mon_exp[19:18]));
            check({cur_tag, ".err"},    32'(mon_got[17]),    32'(mon_exp[17]));
            check({cur_tag, ".we"},     32'(mon_got[16:12]), 32'(mon_exp[16:12]));
            check({cur_tag, ".bubble"}, 32'(mon_got[11:9]),  32'(mon_exp[11:9]));
            check({cur_tag, ".flush"},  32'(mon_got[8:6]),   32'(mon_exp[8:6]));
            check({cur_tag, ".fwd"},    32'(mon_got[5:2]),   32'(mon_exp[5:2]));
            check({cur_tag, ".byp"},    32'(mon_got[1:0]),   32'(mon_exp[1:0]));
        end
    end

    // Independent reference for forwarding / bypass from the match rule.
    function automatic logic [3:0] model_fwd();
        logic [3:0]    f;
        logic [RW-1:0] s;
        f = '0;
        for (int i = 0; i < NS; i++) begin
            s = ex_src[i*RW +: RW];
            if (mem_valid && mem_reg_write && mem_dst != '0 && mem_dst == s) f[2*i +: 2] = 2'b01;
            else if (wb_valid && wb_reg_write && wb_dst != '0 && wb_dst == s) f[2*i +: 2] = 2'b10;
        end
        return f;
    endfunction

    function automatic logic [1:0] model_byp();
        logic [1:0]    b;
        logic [RW-1:0] s;
        b = '0;
        for (int i = 0; i < NS; i++) begin
            s = id_src[i*RW +: RW];
            b[i] = id_valid && id_src_used[i] && wb_valid && wb_reg_write && wb_dst != '0 && wb_dst == s;
        end
        return b;
    endfunction

    // --------------------------------------------------------------- drivers
    task automatic idle();
        id_valid = 1'b0; id_src = '0; id_src_used = '0;
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dst = '0; ex_src = '0;
        ex_mc_start = 1'b0; ex_mc_done = 1'b0;
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_dst = '0; mem_busy = 1'b0;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_dst = '0;
        redirect = 1'b0;
    endtask

    task automatic load_in_ex(input logic [RW-1:0] dst);
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dst = dst;
    endtask

    // Inputs are already applied (posedge+1); queue the expectation and
    // advance to the next posedge+1. The monitor compares on the negedge.
    task automatic step(input string tag, input logic [EW-1:0] exp);
        cur_tag = tag;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step("reset", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));

        // Forwarding priority and r0.
        idle(); mem_valid = 1'b1; mem_reg_write = 1'b1; mem_dst = 5'd5;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_dst = 5'd5; ex_src = {5'd7, 5'd5};
        step("fwd_exmem", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0001, 2'b00));
        idle(); wb_valid = 1'b1; wb_reg_write = 1'b1; wb_dst = 5'd5; ex_src = {5'd7, 5'd5};
        step("fwd_memwb", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0010, 2'b00));
        idle(); mem_valid = 1'b1; mem_reg_write = 1'b1; wb_valid = 1'b1; wb_reg_write = 1'b1;
        step("fwd_r0", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle(); mem_valid = 1'b1; mem_dst = 5'd5; wb_valid = 1'b1; wb_reg_write = 1'b1;
        wb_dst = 5'd5; ex_src = {5'd5, 5'd5};
        step("fwd_nowrite", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b1010, 2'b00));
        idle(); id_valid = 1'b1; id_src = {5'd9, 5'd9}; id_src_used = 2'b10;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_dst = 5'd9;
        step("bypass", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b10));

        // Randomised forwarding/bypass against the reference model.
        for (int k = 0; k < 24; k++) begin
            idle();
            mem_valid = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
            mem_dst = 5'($urandom_range(0, 3));
            wb_valid = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
            wb_dst = 5'($urandom_range(0, 3));
            ex_src = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_valid = 1'($urandom_range(0, 1)); id_src_used = 2'($urandom_range(0, 3));
            id_src = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            step("rnd_fwd", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, model_fwd(), model_byp()));
        end

        // Load-use: one bubble, then release.
        idle(); load_in_ex(5'd3); id_valid = 1'b1; id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
        step("lu_stall", mk(S_RUN, 1'b0, WE_LU, B_IDEX, FL_NONE, 4'b0000, 2'b00));
        idle(); mem_valid = 1'b1; mem_reg_write = 1'b1; mem_dst = 5'd3;
        id_valid = 1'b1; id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
        step("lu_release", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle(); load_in_ex(5'd3); id_valid = 1'b1; id_src = {5'd3, 5'd0}; id_src_used = 2'b01;
        step("lu_unused_src", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle(); load_in_ex(5'd0); id_valid = 1'b1; id_src_used = 2'b11;
        step("lu_r0", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle(); load_in_ex(5'd3); id_valid = 1'b1; id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
        redirect = 1'b1;
        step("lu_redirect", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_BR, 4'b0000, 2'b00));

        // mem_busy beats redirect; MEM_WAIT returns to RUN with no op pending.
        idle(); mem_busy = 1'b1; redirect = 1'b1;
        step("busy_redirect", mk(S_RUN, 1'b0, WE_NONE, B_MEMWB, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("memwait_exit", mk(S_MW, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("memwait_run", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));

        // Multi-cycle op: 5 busy cycles, then done.
        idle(); ex_mc_start = 1'b1;
        step("mc_start", mk(S_RUN, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        for (int k = 0; k < 5; k++) begin
            idle();
            step("mc_busy", mk(S_EXB, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        end
        idle(); ex_mc_done = 1'b1;
        step("mc_done", mk(S_EXB, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("mc_after", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));

        // mem_busy for 3 cycles during EX_BUSY.
        idle(); ex_mc_start = 1'b1;
        step("mcb_start", mk(S_RUN, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("mcb_busy", mk(S_EXB, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        for (int k = 0; k < 3; k++) begin
            idle(); mem_busy = 1'b1;
            step("mcb_memwait", mk((k == 0) ? S_EXB : S_MW, 1'b0, WE_NONE, B_MEMWB, FL_NONE, 4'b0000, 2'b00));
        end
        idle();
        step("mcb_drop", mk(S_MW, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        idle(); ex_mc_done = 1'b1;
        step("mcb_done", mk(S_EXB, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("mcb_after", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));

        // Start and done in the same cycle: no stall, stays in RUN.
        idle(); ex_mc_start = 1'b1; ex_mc_done = 1'b1;
        step("mc_instant", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("mc_instant_after", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));

        // Timeout after MC_TIMEOUT EX_BUSY cycles; sticky until reset.
        idle(); ex_mc_start = 1'b1;
        step("to_start", mk(S_RUN, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        for (int k = 0; k < TO; k++) begin
            idle();
            step("to_busy", mk(S_EXB, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        end
        idle();
        step("to_err", mk(S_RUN, 1'b1, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("to_sticky", mk(S_RUN, 1'b1, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        do_reset();
        step("to_cleared", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));

        // Reset in the middle of a multi-cycle op.
        idle(); ex_mc_start = 1'b1;
        step("rmid_start", mk(S_RUN, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("rmid_busy", mk(S_EXB, 1'b0, WE_MC, B_EXMEM, FL_NONE, 4'b0000, 2'b00));
        do_reset();
        step("rmid_run", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle(); mem_busy = 1'b1;
        step("rmid_busy2", mk(S_RUN, 1'b0, WE_NONE, B_MEMWB, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("rmid_nopend", mk(S_MW, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));
        idle();
        step("rmid_final", mk(S_RUN, 1'b0, WE_ALL, B_NONE, FL_NONE, 4'b0000, 2'b00));

        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
